// File: rtl/midi_src_arbiter.sv
// midi_src_arbiter: buffers UART and CPU MIDI byte streams and merges them one whole message at a time,
// pacing the merged bytes with a one-cycle byteready pulse and a fixed inter-byte gap.
module midi_src_arbiter #(
    parameter int FIFO_DEPTH = 8,
    parameter int OUT_GAP    = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset_reg_N,
    input  logic [1:0] mode,
    input  logic       byteready_u,
    input  logic [7:0] cur_status_u,
    input  logic [7:0] midibyte_nr_u,
    input  logic [7:0] midi_in_data_u,
    input  logic       byteready_c,
    input  logic [7:0] cur_status_c,
    input  logic [7:0] midibyte_nr_c,
    input  logic [7:0] midi_in_data_c,
    output logic       byteready,
    output logic [7:0] cur_status,
    output logic [7:0] midibyte_nr,
    output logic [7:0] midi_in_data,
    output logic       grant_src,
    output logic       locked,
    output logic       ovf_u,
    output logic       ovf_c,
    input  logic       ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(OUT_GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOCK, EMIT, GAP} state_t;
    state_t state, state_n;

    logic [1:0]    br_q, rise, en, push, wr, pop, flush, full, nonempty, cand, ovf, mode_q, mode_e;
    logic [23:0]   mem [2][FIFO_DEPTH];
    logic [23:0]   din [2];
    logic [23:0]   head [2];
    logic [AW-1:0] wp [2];
    logic [AW-1:0] rp [2];
    logic [AW:0]   cnt [2];
    logic [GW-1:0] gcnt;
    logic [TW-1:0] tcnt;
    logic [23:0]   pick;
    logic          sel, go, rr, rr_n, end_q;

    // Entry layout is {status, byte index, data}
    function automatic logic msg_end(input logic [23:0] e);
        return (e[23:16] < 8'h80 || e[23:16] > 8'hF0) ? 1'b1 :
               (e[23:16] == 8'hF0) ? (e[15:8] != 8'd0 && e[7:0] == 8'hF7) :
               (e[23:20] inside {4'hC, 4'hD}) ? (e[15:8] == 8'd1) : (e[15:8] == 8'd2);
    endfunction

    assign din[0]   = {cur_status_u, midibyte_nr_u, midi_in_data_u};
    assign din[1]   = {cur_status_c, midibyte_nr_c, midi_in_data_c};
    // A new mode is only honoured between messages
    assign mode_e   = (state == IDLE) ? mode : mode_q;
    assign en       = {mode_e != 2'b01, mode_e != 2'b10};
    assign rise     = {byteready_c, byteready_u} & ~br_q;
    assign push     = rise & en;
    assign wr       = push & (~full | pop);
    assign flush    = ~en & {2{state == IDLE}};
    assign cand     = en & nonempty;
    assign pop      = go ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign pick     = sel ? head[1] : head[0];
    assign locked   = state != IDLE;
    assign ovf_u    = ovf[0];
    assign ovf_c    = ovf[1];

    for (genvar s = 0; s < 2; s++) begin : g_src
        assign full[s]     = cnt[s] == (AW+1)'(FIFO_DEPTH);
        assign nonempty[s] = cnt[s] != '0;
        assign head[s]     = mem[s][rp[s]];
    end

    always_ff @(posedge CLOCK_50)
        for (int s = 0; s < 2; s++)
            if (wr[s]) mem[s][wp[s]] <= din[s];

    always_comb begin
        state_n = state;
        sel     = grant_src;
        go      = 1'b0;
        rr_n    = rr;
        case (state)
            IDLE: if (|cand) begin
                sel     = &cand ? rr : cand[1];
                go      = 1'b1;
                state_n = EMIT;
            end
            EMIT: state_n = GAP;
            // The last gap cycle may already pop so the byte period stays OUT_GAP+1
            GAP: if (gcnt == GW'(OUT_GAP - 1)) begin
                if (end_q) begin
                    state_n = IDLE;
                    rr_n    = ~grant_src;
                end else if (nonempty[grant_src]) begin
                    go      = 1'b1;
                    state_n = EMIT;
                end else begin
                    state_n = LOCK;
                end
            end
            LOCK: if (nonempty[grant_src]) begin
                go      = 1'b1;
                state_n = EMIT;
            end else if (tcnt + TW'(1) == TW'(TIMEOUT)) begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N)
        if (!reset_reg_N) begin
            state        <= IDLE;
            mode_q       <= '0;
            br_q         <= '0;
            ovf          <= '0;
            gcnt         <= '0;
            tcnt         <= '0;
            rr           <= 1'b0;
            end_q        <= 1'b0;
            grant_src    <= 1'b0;
            byteready    <= 1'b0;
            cur_status   <= '0;
            midibyte_nr  <= '0;
            midi_in_data <= '0;
            for (int s = 0; s < 2; s++) begin
                wp[s]  <= '0;
                rp[s]  <= '0;
                cnt[s] <= '0;
            end
        end else begin
            state     <= state_n;
            mode_q    <= mode_e;
            br_q      <= {byteready_c, byteready_u};
            rr        <= rr_n;
            gcnt      <= (state == GAP) ? gcnt + GW'(1) : '0;
            tcnt      <= (go || state == IDLE) ? '0 : tcnt + TW'(1);
            byteready <= go;
            ovf       <= (ovf & ~{2{ovf_clr}}) | (push & full & ~pop);
            if (go) begin
                {cur_status, midibyte_nr, midi_in_data} <= pick;
                end_q     <= msg_end(pick);
                grant_src <= sel;
            end
            for (int s = 0; s < 2; s++)
                if (flush[s]) begin
                    wp[s]  <= '0;
                    rp[s]  <= '0;
                    cnt[s] <= '0;
                end else begin
                    if (wr[s]) wp[s] <= wp[s] + AW'(1);
                    if (pop[s]) rp[s] <= rp[s] + AW'(1);
                    cnt[s] <= cnt[s] + (AW+1)'(wr[s]) - (AW+1)'(pop[s]);
                end
        end
endmodule

// File: tb/tb_midi_src_arbiter.sv
// tb_midi_src_arbiter: directed scenario bench for the UART/CPU MIDI message arbiter.
module tb_midi_src_arbiter;
    logic       CLOCK_50 = 1'b0;
    logic       reset_reg_N = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       byteready_u = 1'b0, byteready_c = 1'b0, ovf_clr = 1'b0;
    logic [7:0] cur_status_u = '0, midibyte_nr_u = '0, midi_in_data_u = '0;
    logic [7:0] cur_status_c = '0, midibyte_nr_c = '0, midi_in_data_c = '0;
    logic       byteready, grant_src, locked, ovf_u, ovf_c;
    logic [7:0] cur_status, midibyte_nr, midi_in_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic lk_d = 1'b0;

    typedef struct {
        logic        g;
        logic        lk;
        logic [23:0] e;
        int          c;
    } ev_t;
    ev_t evq[$];
    int  falls[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    midi_src_arbiter #(.FIFO_DEPTH(8), .OUT_GAP(4), .TIMEOUT(100)) dut (
        .CLOCK_50(CLOCK_50), .reset_reg_N(reset_reg_N), .mode(mode),
        .byteready_u(byteready_u), .cur_status_u(cur_status_u),
        .midibyte_nr_u(midibyte_nr_u), .midi_in_data_u(midi_in_data_u),
        .byteready_c(byteready_c), .cur_status_c(cur_status_c),
        .midibyte_nr_c(midibyte_nr_c), .midi_in_data_c(midi_in_data_c),
        .byteready(byteready), .cur_status(cur_status), .midibyte_nr(midibyte_nr),
        .midi_in_data(midi_in_data), .grant_src(grant_src), .locked(locked),
        .ovf_u(ovf_u), .ovf_c(ovf_c), .ovf_clr(ovf_clr)
    );

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Log every emitted byte and every falling edge of locked, sampled mid-cycle
    always @(negedge CLOCK_50) begin
        if (byteready) evq.push_back('{g: grant_src, lk: locked, e: {cur_status, midibyte_nr, midi_in_data}, c: cyc});
        if (lk_d && !locked) falls.push_back(cyc);
        lk_d = locked;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset_reg_N = 1'b0;
        mode = 2'b00;
        idle(2);
        reset_reg_N = 1'b1;
        evq.delete();
        falls.delete();
    endtask

    task automatic push_u(input logic [7:0] s, input logic [7:0] n, input logic [7:0] d);
        @(negedge CLOCK_50);
        cur_status_u = s; midibyte_nr_u = n; midi_in_data_u = d; byteready_u = 1'b1;
        @(negedge CLOCK_50);
        byteready_u = 1'b0;
    endtask

    task automatic push_c(input logic [7:0] s, input logic [7:0] n, input logic [7:0] d);
        @(negedge CLOCK_50);
        cur_status_c = s; midibyte_nr_c = n; midi_in_data_c = d; byteready_c = 1'b1;
        @(negedge CLOCK_50);
        byteready_c = 1'b0;
    endtask

    task automatic push_both(input logic [23:0] u, input logic [23:0] c);
        @(negedge CLOCK_50);
        {cur_status_u, midibyte_nr_u, midi_in_data_u} = u; byteready_u = 1'b1;
        {cur_status_c, midibyte_nr_c, midi_in_data_c} = c; byteready_c = 1'b1;
        @(negedge CLOCK_50);
        byteready_u = 1'b0;
        byteready_c = 1'b0;
    endtask

    task automatic wait_locked(input string tag);
        for (int i = 0; i < 20 && !locked; i++) @(negedge CLOCK_50);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL %s_lock: locked=%b, want 1 within 20 cycles", tag, locked);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({byteready, locked, grant_src, ovf_u, ovf_c} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: br/lk/gs/ovfu/ovfc=%b, want 00000", {byteready, locked, grant_src, ovf_u, ovf_c});
        end
        checks++;
        if ({cur_status, midibyte_nr, midi_in_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_fields: %h, want 000000", {cur_status, midibyte_nr, midi_in_data});
        end
        idle(10);
        checks++;
        if (evq.size() !== 0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: events=%0d locked=%b, want 0 and 0", evq.size(), locked);
        end
    endtask

    task automatic test_note_on();
        logic [23:0] exp [3];
        exp = '{24'h90_00_90, 24'h90_01_3C, 24'h90_02_64};
        push_u(8'h90, 8'd0, 8'h90);
        push_u(8'h90, 8'd1, 8'h3C);
        push_u(8'h90, 8'd2, 8'h64);
        idle(40);
        checks++;
        if (evq.size() !== 3) begin
            errors++;
            $display("FAIL note_on_count: got %0d bytes, want 3", evq.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= evq.size() || evq[i].e !== exp[i] || evq[i].g !== 1'b0 || evq[i].lk !== 1'b1) begin
                errors++;
                $display("FAIL note_on_byte%0d: got %h src %b lk %b, want %h src 0 lk 1", i, evq[i].e, evq[i].g, evq[i].lk, exp[i]);
            end
        end
        checks++;
        if (evq.size() < 3 || evq[1].c - evq[0].c != 5 || evq[2].c - evq[1].c != 5) begin
            errors++;
            $display("FAIL note_on_spacing: got %0d,%0d cycles, want 5,5", evq[1].c - evq[0].c, evq[2].c - evq[1].c);
        end
        checks++;
        if (falls.size() != 1 || evq.size() < 3 || falls[0] - evq[2].c != 5) begin
            errors++;
            $display("FAIL note_on_unlock: falls=%0d, unlock %0d cycles after last byte, want 1 fall after 5", falls.size(), falls[0] - evq[2].c);
        end
    endtask

    task automatic test_both();
        logic [23:0] exp [6];
        logic [5:0]  exp_g;
        exp = '{24'h90_00_90, 24'h90_01_40, 24'h90_02_7F, 24'hB0_00_B0, 24'hB0_01_07, 24'hB0_02_10};
        exp_g = 6'b111000;
        do_reset();
        push_both(24'h90_00_90, 24'hB0_00_B0);
        push_both(24'h90_01_40, 24'hB0_01_07);
        push_both(24'h90_02_7F, 24'hB0_02_10);
        idle(60);
        checks++;
        if (evq.size() !== 6) begin
            errors++;
            $display("FAIL both_count: got %0d bytes, want 6", evq.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= evq.size() || evq[i].e !== exp[i] || evq[i].g !== exp_g[i]) begin
                errors++;
                $display("FAIL both_byte%0d: got %h src %b, want %h src %b", i, evq[i].e, evq[i].g, exp[i], exp_g[i]);
            end
        end
        checks++;
        if (falls.size() != 2) begin
            errors++;
            $display("FAIL both_unlocks: got %0d lock releases, want 2", falls.size());
        end
    endtask

    task automatic test_sysex_pc();
        logic [23:0] exp [6];
        logic [5:0]  exp_g;
        exp = '{24'hF0_00_F0, 24'hF0_01_43, 24'hF0_02_10, 24'hF0_03_F7, 24'hC0_00_C0, 24'hC0_01_05};
        exp_g = 6'b110000;
        evq.delete();
        falls.delete();
        push_u(8'hF0, 8'd0, 8'hF0);
        wait_locked("sysex");
        push_c(8'hC0, 8'd0, 8'hC0);
        push_c(8'hC0, 8'd1, 8'h05);
        push_u(8'hF0, 8'd1, 8'h43);
        push_u(8'hF0, 8'd2, 8'h10);
        push_u(8'hF0, 8'd3, 8'hF7);
        idle(60);
        checks++;
        if (evq.size() !== 6) begin
            errors++;
            $display("FAIL sysex_count: got %0d bytes, want 6", evq.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= evq.size() || evq[i].e !== exp[i] || evq[i].g !== exp_g[i]) begin
                errors++;
                $display("FAIL sysex_byte%0d: got %h src %b, want %h src %b", i, evq[i].e, evq[i].g, exp[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [23:0] exp [5];
        logic [4:0]  exp_g;
        exp = '{24'h90_00_90, 24'h90_01_3C, 24'h80_00_80, 24'h80_01_3C, 24'h80_02_00};
        exp_g = 5'b11100;
        evq.delete();
        falls.delete();
        push_u(8'h90, 8'd0, 8'h90);
        push_u(8'h90, 8'd1, 8'h3C);
        push_c(8'h80, 8'd0, 8'h80);
        push_c(8'h80, 8'd1, 8'h3C);
        push_c(8'h80, 8'd2, 8'h00);
        idle(180);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= evq.size() || evq[i].e !== exp[i] || evq[i].g !== exp_g[i]) begin
                errors++;
                $display("FAIL timeout_byte%0d: got %h src %b, want %h src %b", i, evq[i].e, evq[i].g, exp[i], exp_g[i]);
            end
        end
        checks++;
        if (falls.size() < 1 || evq.size() < 2 || falls[0] - evq[1].c != 100) begin
            errors++;
            $display("FAIL timeout_release: unlock %0d cycles after last pop, want 100", falls[0] - evq[1].c);
        end
        checks++;
        if (falls.size() < 1 || evq.size() < 3 || evq[2].c - falls[0] != 1) begin
            errors++;
            $display("FAIL timeout_regrant: CPU byte %0d cycles after release, want 1", evq[2].c - falls[0]);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        push_c(8'h90, 8'd0, 8'h90);
        wait_locked("ovf");
        for (int i = 0; i < 8; i++) push_u(8'hF8, 8'd0, 8'(i));
        checks++;
        if (ovf_u !== 1'b0) begin
            errors++;
            $display("FAIL ovf_exact_full: ovf_u=%b, want 0", ovf_u);
        end
        push_u(8'hF8, 8'd0, 8'h08);
        checks++;
        if (ovf_u !== 1'b1 || ovf_c !== 1'b0) begin
            errors++;
            $display("FAIL ovf_set: ovf_u=%b ovf_c=%b, want 1 0", ovf_u, ovf_c);
        end
        @(negedge CLOCK_50);
        cur_status_u = 8'hF8; midibyte_nr_u = 8'd0; midi_in_data_u = 8'h09;
        byteready_u = 1'b1; ovf_clr = 1'b1;
        @(negedge CLOCK_50);
        byteready_u = 1'b0; ovf_clr = 1'b0;
        checks++;
        if (ovf_u !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf_u=%b, want 1", ovf_u);
        end
        @(negedge CLOCK_50);
        ovf_clr = 1'b1;
        @(negedge CLOCK_50);
        ovf_clr = 1'b0;
        checks++;
        if (ovf_u !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf_u=%b, want 0", ovf_u);
        end
        idle(200);
        checks++;
        if (evq.size() !== 9 || evq[0].e !== 24'h90_00_90 || evq[0].g !== 1'b1) begin
            errors++;
            $display("FAIL ovf_count: got %0d bytes first %h, want 9 first 900090", evq.size(), evq[0].e);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i + 1 >= evq.size() || evq[i+1].e !== {16'hF8_00, 8'(i)} || evq[i+1].g !== 1'b0) begin
                errors++;
                $display("FAIL ovf_byte%0d: got %h src %b, want %h src 0", i, evq[i+1].e, evq[i+1].g, {16'hF8_00, 8'(i)});
            end
        end
    endtask

    task automatic test_mode_excl();
        do_reset();
        push_u(8'h90, 8'd0, 8'h90);
        wait_locked("excl");
        push_c(8'hB0, 8'd0, 8'hB0);
        push_c(8'hB0, 8'd1, 8'h07);
        push_c(8'hB0, 8'd2, 8'h10);
        mode = 2'b01;
        idle(150);
        checks++;
        if (evq.size() !== 1 || evq[0].g !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL excl_uart_only: got %0d bytes locked %b, want 1 UART byte and unlocked", evq.size(), locked);
        end
        mode = 2'b00;
        idle(40);
        checks++;
        if (evq.size() !== 1) begin
            errors++;
            $display("FAIL excl_flushed: got %0d bytes after re-enable, want 1", evq.size());
        end
    endtask

    task automatic test_reset_mid_emit();
        do_reset();
        push_u(8'h90, 8'd0, 8'h90);
        push_u(8'h90, 8'd1, 8'h3C);
        push_u(8'h90, 8'd2, 8'h64);
        for (int i = 0; i < 20 && !byteready; i++) @(negedge CLOCK_50);
        checks++;
        if (byteready !== 1'b1) begin
            errors++;
            $display("FAIL rst_emit_reach: byteready=%b, want 1 within 20 cycles", byteready);
        end
        #1 reset_reg_N = 1'b0;
        #1;
        checks++;
        if ({byteready, locked, cur_status, midibyte_nr, midi_in_data} !== 26'h0) begin
            errors++;
            $display("FAIL rst_emit_async: br=%b lk=%b fields=%h, want all 0", byteready, locked, {cur_status, midibyte_nr, midi_in_data});
        end
        idle(2);
        reset_reg_N = 1'b1;
        evq.delete();
        idle(30);
        checks++;
        if (evq.size() !== 0) begin
            errors++;
            $display("FAIL rst_emit_fifo: got %0d bytes after reset, want 0", evq.size());
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_both();
        test_sysex_pc();
        test_timeout();
        test_overflow();
        test_mode_excl();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
